// File: rtl/armv8_pkg.sv
// armv8_pkg: shared register-file widths, address/data types and reset-value helper.
package armv8_pkg;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS = 32;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] dword_t;
    typedef dword_t reg_array_t [NREGS-1];
    localparam reg_addr_t ZR_IDX = 5'd31;
    function automatic reg_array_t init_regs();
        reg_array_t r;
        for (int i = 0; i < int'(NREGS) - 1; i++) r[i] = DATA_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 32 x 64-bit register file, two async read ports, one sync write port, X31 hard-wired to zero.
module regfile
    import armv8_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      we3,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    input  reg_addr_t wa3,
    input  dword_t    wd3,
    output dword_t    rd1,
    output dword_t    rd2
);
    reg_array_t regs = init_regs();
    logic       wr;
    // Only a fully known enable and address may write, so X never spreads into unaddressed registers.
    assign wr = (we3 === 1'b1) && !$isunknown(wa3) && (wa3 != ZR_IDX);
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NREGS) - 1; i++)
            regs[i] <= reset ? DATA_W'(i) : (wr && wa3 == reg_addr_t'(i)) ? wd3 : regs[i];
    end
    assign rd1 = (ra1 == ZR_IDX) ? '0 : regs[ra1];
    assign rd2 = (ra2 == ZR_IDX) ? '0 : regs[ra2];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile.
module tb_regfile;
    import armv8_pkg::*;
    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      we3 = 1'b0;
    reg_addr_t ra1 = '0;
    reg_addr_t ra2 = '0;
    reg_addr_t wa3 = '0;
    dword_t    wd3 = '0;
    dword_t    rd1;
    dword_t    rd2;
    int        total = 0;
    int        passed = 0;

    regfile dut (
        .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2),
        .wa3(wa3), .wd3(wd3), .rd1(rd1), .rd2(rd2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        ra1 = 5'd0;
        ra2 = 5'd30;
        #1;
        total++;
        if (rd1 !== 64'd0) $display("FAIL reset_x0 rd1=%h expected=%h", rd1, 64'd0);
        else passed++;
        total++;
        if (rd2 !== 64'd30) $display("FAIL reset_x30 rd2=%h expected=%h", rd2, 64'd30);
        else passed++;
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            ra1 = 5'(i);
            ra2 = 5'(i);
            #1;
            total++;
            if (rd1 !== 64'(i) || rd2 !== 64'(i))
                $display("FAIL init_sweep idx=%0d rd1=%h rd2=%h expected=%h", i, rd1, rd2, 64'(i));
            else passed++;
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        ra1 = 5'd31;
        ra2 = 5'd31;
        #1;
        total++;
        if (rd1 !== 64'h0 || rd2 !== 64'h0)
            $display("FAIL zero_reg rd1=%h rd2=%h expected=0", rd1, rd2);
        else passed++;
    endtask

    task automatic test_write_disabled();
        @(negedge clk);
        we3 = 1'b0;
        wa3 = 5'd14;
        wd3 = 64'hFFFF_AAAA_FFFF_CCCC;
        ra1 = 5'd14;
        tick();
        total++;
        if (rd1 !== 64'd14) $display("FAIL write_disabled rd1=%h expected=%h", rd1, 64'd14);
        else passed++;
    endtask

    task automatic test_write_enabled();
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 5'd14;
        wd3 = 64'hFFFF_AAAA_FFFF_CCCC;
        ra1 = 5'd14;
        #1;
        total++;
        if (rd1 !== 64'd14) $display("FAIL no_bypass rd1=%h expected=%h", rd1, 64'd14);
        else passed++;
        tick();
        total++;
        if (rd1 !== 64'hFFFF_AAAA_FFFF_CCCC)
            $display("FAIL write_enabled rd1=%h expected=%h", rd1, 64'hFFFF_AAAA_FFFF_CCCC);
        else passed++;
        @(negedge clk);
        we3 = 1'b0;
        ra1 = 5'd13;
        ra2 = 5'd15;
        #1;
        total++;
        if (rd1 !== 64'd13 || rd2 !== 64'd15)
            $display("FAIL neighbours rd1=%h rd2=%h expected=%h/%h", rd1, rd2, 64'd13, 64'd15);
        else passed++;
    endtask

    task automatic test_xzr_write();
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 5'd31;
        wd3 = 64'hDEAD_BEEF_0000_0001;
        ra1 = 5'd31;
        ra2 = 5'd30;
        tick();
        total++;
        if (rd1 !== 64'h0) $display("FAIL xzr_write rd1=%h expected=0", rd1);
        else passed++;
        total++;
        if (rd2 !== 64'd30) $display("FAIL xzr_side_effect rd2=%h expected=%h", rd2, 64'd30);
        else passed++;
        @(negedge clk);
        we3 = 1'b0;
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 5'd14;
        wd3 = 64'h0BAD_F00D_0000_0014;
        ra1 = 5'd14;
        tick();
        total++;
        if (rd1 !== 64'h0BAD_F00D_0000_0014)
            $display("FAIL pre_reset_write rd1=%h expected=%h", rd1, 64'h0BAD_F00D_0000_0014);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        we3 = 1'b1;
        wa3 = 5'd5;
        wd3 = 64'h1234;
        tick();
        @(negedge clk);
        reset = 1'b0;
        we3 = 1'b0;
        ra1 = 5'd5;
        ra2 = 5'd14;
        #1;
        total++;
        if (rd1 !== 64'd5) $display("FAIL reset_priority_x5 rd1=%h expected=%h", rd1, 64'd5);
        else passed++;
        total++;
        if (rd2 !== 64'd14) $display("FAIL reset_priority_x14 rd2=%h expected=%h", rd2, 64'd14);
        else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 5'd0;
        wd3 = 64'h1111_2222_3333_4444;
        tick();
        @(negedge clk);
        wa3 = 5'd30;
        wd3 = 64'h5555_6666_7777_8888;
        tick();
        @(negedge clk);
        we3 = 1'b0;
        ra1 = 5'd0;
        ra2 = 5'd30;
        #1;
        total++;
        if (rd1 !== 64'h1111_2222_3333_4444 || rd2 !== 64'h5555_6666_7777_8888)
            $display("FAIL back_to_back rd1=%h rd2=%h expected=%h/%h", rd1, rd2,
                     64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_zero_reg();
        test_write_disabled();
        test_write_enabled();
        test_xzr_write();
        test_reset_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
